// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory request/response bus between fetch_unit and memory
//
// Purpose : bundles the instruction-memory handshake so it travels as one port.
// Signals : imem_req_valid  fetch -> mem  request valid
//           imem_req_addr   fetch -> mem  word-aligned request address
//           imem_req_ready  mem -> fetch  request accepted this cycle
//           imem_rsp_valid  mem -> fetch  one-cycle response pulse
//           imem_rsp_data   mem -> fetch  instruction word
// Modports: master (fetch side), slave (memory side)

interface fetch_unit_if;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;

   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rsp_data
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rsp_data
   );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with one outstanding request and IF/ID register
//
// Purpose : issues word-aligned fetches, captures responses into the IF/ID
//           register, absorbs hazard stalls with a one-entry skid and handles
//           redirects (flush) including discarding a stale in-flight response.
// Ports   : clk, rst        core clock, asynchronous active-high reset
//           npc, flush      redirect target / redirect request
//           stall           hazard hold of IF/ID and fetch PC
//           imem            fetch_unit_if.master instruction-memory bus
//           ifid_valid/pc/pc4/inst   IF/ID register contents
//           fetch_cnt, flush_cnt     performance counters
// Config  : FETCH_PERF_CNT_EN defined builds the counters; undefined ties
//           fetch_cnt and flush_cnt to zero.

module fetch_unit (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         npc,
   input  logic                flush,
   input  logic                stall,
   fetch_unit_if.master        imem,
   output logic                ifid_valid,
   output logic [31:0]         ifid_pc,
   output logic [31:0]         ifid_pc4,
   output logic [31:0]         ifid_inst,
   output logic [31:0]         fetch_cnt,
   output logic [31:0]         flush_cnt
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_DROP = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] r_req_pc;
   logic [31:0] r_hold_pc;
   logic [31:0] r_hold_inst;
   logic        r_ifid_valid;
   logic [31:0] r_ifid_pc;
   logic [31:0] r_ifid_pc4;
   logic [31:0] r_ifid_inst;

   logic        w_accept;      // request handshake completes this cycle
   logic        w_load_rsp;    // IF/ID loads directly from the memory response
   logic        w_load_hold;   // IF/ID loads from the skid entry
   logic        w_capture;     // response parked in the skid entry
   logic        w_bubble;      // nothing to load and not stalled
   logic [31:0] w_npc_aligned;
   logic [31:0] w_ld_pc;
   logic [31:0] w_ld_inst;

   assign w_npc_aligned = npc & 32'hFFFF_FFFC;

   // Request is driven combinationally from the current PC so the address
   // only moves while valid is high when the PC itself is redirected.
   assign imem.imem_req_valid = (r_state == S_REQ);
   assign imem.imem_req_addr  = r_pc;

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_load_rsp  = 1'b0;
      w_load_hold = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         S_REQ: begin
            if (flush) begin
               // An accepted request is still in flight: its response is stale.
               w_state_nxt = imem.imem_req_ready ? S_DROP : S_REQ;
            end else if (imem.imem_req_ready) begin
               w_accept    = 1'b1;
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (flush) begin
               w_state_nxt = imem.imem_rsp_valid ? S_REQ : S_DROP;
            end else if (imem.imem_rsp_valid) begin
               if (stall) begin
                  w_capture   = 1'b1;
                  w_state_nxt = S_HOLD;
               end else begin
                  w_load_rsp  = 1'b1;
                  w_state_nxt = S_REQ;
               end
            end
         end
         S_HOLD: begin
            if (flush) begin
               w_state_nxt = S_REQ;
            end else if (!stall) begin
               w_load_hold = 1'b1;
               w_state_nxt = S_REQ;
            end
         end
         S_DROP: begin
            if (imem.imem_rsp_valid) begin
               w_state_nxt = S_REQ;
            end
         end
         default: w_state_nxt = S_REQ;
      endcase
   end

   assign w_bubble  = !flush && !stall && !w_load_rsp && !w_load_hold;
   assign w_ld_pc   = w_load_hold ? r_hold_pc   : r_req_pc;
   assign w_ld_inst = w_load_hold ? r_hold_inst : imem.imem_rsp_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_REQ;
         r_pc        <= 32'h0;
         r_req_pc    <= 32'h0;
         r_hold_pc   <= 32'h0;
         r_hold_inst <= 32'h0;
      end else begin
         r_state <= w_state_nxt;
         if (flush) begin
            r_pc        <= w_npc_aligned;
            r_hold_pc   <= 32'h0;
            r_hold_inst <= 32'h0;
         end else begin
            if (w_accept) begin
               r_req_pc <= r_pc;
               r_pc     <= r_pc + 32'd4;
            end
            if (w_capture) begin
               r_hold_pc   <= r_req_pc;
               r_hold_inst <= imem.imem_rsp_data;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ifid_valid <= 1'b0;
         r_ifid_pc    <= 32'h0;
         r_ifid_pc4   <= 32'h4;
         r_ifid_inst  <= NOP;
      end else if (flush) begin
         r_ifid_valid <= 1'b0;
      end else if (w_load_rsp || w_load_hold) begin
         r_ifid_valid <= 1'b1;
         r_ifid_pc    <= w_ld_pc;
         r_ifid_pc4   <= w_ld_pc + 32'd4;
         r_ifid_inst  <= w_ld_inst;
      end else if (w_bubble) begin
         r_ifid_valid <= 1'b0;
      end
   end

   assign ifid_valid = r_ifid_valid;
   assign ifid_pc    = r_ifid_pc;
   assign ifid_pc4   = r_ifid_pc4;
   assign ifid_inst  = r_ifid_inst;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_fetch_cnt;
   logic [31:0] r_flush_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_cnt <= 32'h0;
         r_flush_cnt <= 32'h0;
      end else begin
         if (!flush && (w_load_rsp || w_load_hold)) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
         end
         if (flush) begin
            r_flush_cnt <= r_flush_cnt + 32'd1;
         end
      end
   end

   assign fetch_cnt = r_fetch_cnt;
   assign flush_cnt = r_flush_cnt;
`else
   assign fetch_cnt = 32'h0;
   assign flush_cnt = 32'h0;
`endif

endmodule
